// File: rtl/branch_redirect_ctrl_if.sv
// Purpose: EX-to-controller inputs plus the redirect valid/ready channel towards fetch.
// Latency: wires only, no storage.
// Backpressure: fetch stalls the redirect by holding redirect_ready low.
interface branch_redirect_ctrl_if;
    logic        ex_valid;
    logic        ex_is_ctrl;
    logic        ex_taken;
    logic [31:0] ex_pc;
    logic [31:0] ex_target;
    logic        redirect_valid;
    logic        redirect_ready;
    logic [31:0] redirect_pc;

    // Controller side: consumes EX results, drives the redirect request.
    modport master (
        input  ex_valid,
        input  ex_is_ctrl,
        input  ex_taken,
        input  ex_pc,
        input  ex_target,
        input  redirect_ready,
        output redirect_valid,
        output redirect_pc
    );

    // Pipeline side: EX drives results, fetch accepts redirects.
    modport slave (
        output ex_valid,
        output ex_is_ctrl,
        output ex_taken,
        output ex_pc,
        output ex_target,
        output redirect_ready,
        input  redirect_valid,
        input  redirect_pc
    );
endinterface

// File: rtl/branch_redirect_ctrl.sv
// Purpose: turns resolved EX control instructions into fetch redirects, flushes and misaligned-target traps.
// Latency: registered outputs, redirect/trap appear one cycle after the EX instruction is accepted.
// Backpressure: redirect_valid holds until redirect_ready; busy stays high through the drain so EX cannot issue.
module branch_redirect_ctrl #(
    parameter int DRAIN_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    branch_redirect_ctrl_if.master rdr,
    input  logic                   cnt_clr,
    output logic                   flush,
    output logic                   busy,
    output logic                   trap_valid,
    output logic [31:0]            trap_pc,
    output logic [CNT_W-1:0]       branch_cnt,
    output logic [CNT_W-1:0]       taken_cnt
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        DRAIN    = 2'd2
    } state_e;

    localparam logic [3:0] DRAIN_LD = 4'(DRAIN_CYCLES);

    state_e           state_q, state_d;
    logic [3:0]       drain_cnt_q, drain_cnt_d;
    logic             redirect_valid_q, redirect_valid_d;
    logic [31:0]      redirect_pc_q, redirect_pc_d;
    logic             flush_q, flush_d;
    logic             busy_q, busy_d;
    logic             trap_valid_q, trap_valid_d;
    logic [31:0]      trap_pc_q, trap_pc_d;
    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
    logic             branch_inc;
    logic             taken_inc;

    // Next-state and registered-output computation; EX inputs only matter in IDLE.
    always_comb begin
        state_d          = state_q;
        drain_cnt_d      = drain_cnt_q;
        redirect_valid_d = redirect_valid_q;
        redirect_pc_d    = redirect_pc_q;
        flush_d          = flush_q;
        busy_d           = busy_q;
        trap_valid_d     = 1'b0;
        trap_pc_d        = trap_pc_q;
        branch_inc       = 1'b0;
        taken_inc        = 1'b0;

        case (state_q)
            IDLE: begin
                if (rdr.ex_valid && rdr.ex_is_ctrl) begin
                    branch_inc = 1'b1;
                    if (rdr.ex_taken) begin
                        if (rdr.ex_target[1:0] != 2'b00) begin
                            // Misaligned target: report and stay on the current path.
                            trap_valid_d = 1'b1;
                            trap_pc_d    = rdr.ex_pc;
                        end else begin
                            state_d          = REDIRECT;
                            redirect_valid_d = 1'b1;
                            redirect_pc_d    = rdr.ex_target;
                            flush_d          = 1'b1;
                            busy_d           = 1'b1;
                        end
                    end
                end
            end
            REDIRECT: begin
                if (rdr.redirect_ready) begin
                    taken_inc        = 1'b1;
                    redirect_valid_d = 1'b0;
                    if (DRAIN_CYCLES == 0) begin
                        state_d = IDLE;
                        flush_d = 1'b0;
                        busy_d  = 1'b0;
                    end else begin
                        state_d     = DRAIN;
                        drain_cnt_d = DRAIN_LD;
                    end
                end
            end
            DRAIN: begin
                drain_cnt_d = drain_cnt_q - 4'd1;
                if (drain_cnt_q == 4'd1) begin
                    state_d = IDLE;
                    flush_d = 1'b0;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d          = IDLE;
                redirect_valid_d = 1'b0;
                flush_d          = 1'b0;
                busy_d           = 1'b0;
            end
        endcase

        // Clear wins over a same-cycle increment.
        branch_cnt_d = cnt_clr ? '0 : branch_cnt_q + CNT_W'(branch_inc);
        taken_cnt_d  = cnt_clr ? '0 : taken_cnt_q + CNT_W'(taken_inc);
    end

    // State and output registers; reset abandons any redirect in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            drain_cnt_q      <= 4'd0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 32'd0;
            flush_q          <= 1'b0;
            busy_q           <= 1'b0;
            trap_valid_q     <= 1'b0;
            trap_pc_q        <= 32'd0;
            branch_cnt_q     <= '0;
            taken_cnt_q      <= '0;
        end else begin
            state_q          <= state_d;
            drain_cnt_q      <= drain_cnt_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            flush_q          <= flush_d;
            busy_q           <= busy_d;
            trap_valid_q     <= trap_valid_d;
            trap_pc_q        <= trap_pc_d;
            branch_cnt_q     <= branch_cnt_d;
            taken_cnt_q      <= taken_cnt_d;
        end
    end

    assign rdr.redirect_valid = redirect_valid_q;
    assign rdr.redirect_pc    = redirect_pc_q;
    assign flush              = flush_q;
    assign busy               = busy_q;
    assign trap_valid         = trap_valid_q;
    assign trap_pc            = trap_pc_q;
    assign branch_cnt         = branch_cnt_q;
    assign taken_cnt          = taken_cnt_q;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Purpose: scoreboard bench for branch_redirect_ctrl (4-bit counters so wrap is reachable).
// Latency: expects redirect/trap one cycle after acceptance, flush for 1+DRAIN_CYCLES cycles.
// Backpressure: exercises stalled and single-cycle redirect handshakes.
module tb_branch_redirect_ctrl;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cnt_clr = 1'b0;
    logic             flush;
    logic             busy;
    logic             trap_valid;
    logic [31:0]      trap_pc;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] taken_cnt;

    int total = 0;
    int bad   = 0;

    logic [31:0]      exp_redir[$];
    logic [31:0]      exp_trap[$];
    logic [CNT_W-1:0] mb = '0;
    logic [CNT_W-1:0] mt = '0;
    logic             prev_trap = 1'b0;

    always #5 clk = ~clk;

    branch_redirect_ctrl_if bif ();

    branch_redirect_ctrl #(.DRAIN_CYCLES(2), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rdr        (bif),
        .cnt_clr    (cnt_clr),
        .flush      (flush),
        .busy       (busy),
        .trap_valid (trap_valid),
        .trap_pc    (trap_pc),
        .branch_cnt (branch_cnt),
        .taken_cnt  (taken_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard side: compare every redirect handshake and trap pulse against queued expectations.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bif.redirect_valid && bif.redirect_ready) begin
                if (exp_redir.size() == 0) check("redir_spurious", 64'(exp_redir.size()), 64'(1));
                else check("redirect_pc", 64'(bif.redirect_pc), 64'(exp_redir.pop_front()));
            end
            if (trap_valid) begin
                if (exp_trap.size() == 0) check("trap_spurious", 64'(exp_trap.size()), 64'(1));
                else check("trap_pc", 64'(trap_pc), 64'(exp_trap.pop_front()));
                check("trap_excl_redir", 64'(bif.redirect_valid), 64'(0));
                check("trap_single_pulse", 64'(prev_trap), 64'(0));
            end
            prev_trap = trap_valid;
        end else begin
            prev_trap = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a control instruction on EX and record what it must produce.
    task automatic drive_ex(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
        bif.ex_valid   = 1'b1;
        bif.ex_is_ctrl = 1'b1;
        bif.ex_taken   = tk;
        bif.ex_pc      = pc;
        bif.ex_target  = tgt;
        mb = mb + 1'b1;
        if (tk) begin
            if (tgt[1:0] != 2'b00) begin
                exp_trap.push_back(pc);
            end else begin
                exp_redir.push_back(tgt);
                mt = mt + 1'b1;
            end
        end
    endtask

    task automatic issue(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
        drive_ex(pc, tgt, tk);
        step();
        bif.ex_valid = 1'b0;
    endtask

    // Returns at a negedge where busy is low (bounded).
    task automatic wait_not_busy();
        int n = 0;
        @(negedge clk);
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("busy_timeout", 64'(busy), 64'(0));
    endtask

    task automatic wait_idle();
        wait_not_busy();
        step();
    endtask

    task automatic check_cnts(input string tag);
        check({tag, "_branch_cnt"}, 64'(branch_cnt), 64'(mb));
        check({tag, "_taken_cnt"}, 64'(taken_cnt), 64'(mt));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int fl;
        int rv;
        bif.ex_valid       = 1'b0;
        bif.ex_is_ctrl     = 1'b0;
        bif.ex_taken       = 1'b0;
        bif.ex_pc          = 32'd0;
        bif.ex_target      = 32'd0;
        bif.redirect_ready = 1'b0;

        // Reset state
        #12;
        check("rst_redirect_valid", 64'(bif.redirect_valid), 64'(0));
        check("rst_redirect_pc", 64'(bif.redirect_pc), 64'(0));
        check("rst_flush", 64'(flush), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_trap_valid", 64'(trap_valid), 64'(0));
        check("rst_trap_pc", 64'(trap_pc), 64'(0));
        check_cnts("rst");
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // 1: not-taken branch
        issue(32'h8, 32'h80, 1'b0);
        @(negedge clk);
        check_cnts("nt");
        check("nt_redirect_valid", 64'(bif.redirect_valid), 64'(0));
        check("nt_flush", 64'(flush), 64'(0));
        check("nt_busy", 64'(busy), 64'(0));
        step();

        // 2: JAL with ready held high
        bif.redirect_ready = 1'b1;
        issue(32'h10, 32'h100, 1'b1);
        fl = 0;
        rv = 0;
        repeat (8) begin
            @(negedge clk);
            fl += int'(flush);
            rv += int'(bif.redirect_valid);
        end
        check("jal_flush_cycles", 64'(fl), 64'(3));
        check("jal_rv_cycles", 64'(rv), 64'(1));
        check("jal_busy_after", 64'(busy), 64'(0));
        check_cnts("jal");
        step();

        // Back-to-back: branch held on EX during drain is accepted once, in the first IDLE cycle
        issue(32'h14, 32'h200, 1'b1);
        drive_ex(32'h18, 32'h300, 1'b0);
        wait_not_busy();
        step();
        bif.ex_valid = 1'b0;
        @(negedge clk);
        check_cnts("b2b");
        step();

        // 3: stalled redirect with wrong-path EX activity
        bif.redirect_ready = 1'b0;
        issue(32'h20, 32'h400, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stall_rv", 64'(bif.redirect_valid), 64'(1));
            check("stall_pc", 64'(bif.redirect_pc), 64'(32'h400));
            step();
            bif.ex_valid   = 1'b1;
            bif.ex_is_ctrl = 1'b1;
            bif.ex_taken   = i[0];
            bif.ex_pc      = $urandom;
            bif.ex_target  = $urandom & 32'hFFFF_FFFC;
        end
        bif.ex_valid       = 1'b0;
        bif.redirect_ready = 1'b1;
        @(negedge clk);
        check("stall_rv_5th", 64'(bif.redirect_valid), 64'(1));
        check("stall_pc_5th", 64'(bif.redirect_pc), 64'(32'h400));
        wait_idle();
        @(negedge clk);
        check_cnts("stall");
        step();

        // 4: misaligned target trap
        issue(32'h40, 32'h102, 1'b1);
        @(negedge clk);
        check("trap_pulse_hi", 64'(trap_valid), 64'(1));
        check("trap_no_redirect", 64'(bif.redirect_valid), 64'(0));
        check("trap_not_busy", 64'(busy), 64'(0));
        @(negedge clk);
        check("trap_pulse_lo", 64'(trap_valid), 64'(0));
        check("trap_pc_hold", 64'(trap_pc), 64'(32'h40));
        check_cnts("trap");
        step();

        // 5: counter wrap and clear priority
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        mb = '0;
        mt = '0;
        @(negedge clk);
        check_cnts("clr");
        step();
        repeat (15) begin
            issue(32'h100, 32'h1000, 1'b1);
            wait_idle();
        end
        @(negedge clk);
        check("wrap_taken_15", 64'(taken_cnt), 64'(15));
        step();
        issue(32'h104, 32'h1004, 1'b1);
        wait_idle();
        @(negedge clk);
        check("wrap_taken_0", 64'(taken_cnt), 64'(0));
        check_cnts("wrap");
        step();
        cnt_clr = 1'b1;
        issue(32'h50, 32'h60, 1'b0);
        cnt_clr = 1'b0;
        mb = '0;
        mt = '0;
        @(negedge clk);
        check_cnts("clr_prio");
        step();

        // 6: reset during REDIRECT, then immediate acceptance after release
        bif.redirect_ready = 1'b0;
        issue(32'h70, 32'h700, 1'b1);
        @(negedge clk);
        check("pre_rst_rv", 64'(bif.redirect_valid), 64'(1));
        #2;
        rst_n = 1'b0;
        exp_redir.delete();
        mb = '0;
        mt = '0;
        #1;
        check("mid_rst_rv", 64'(bif.redirect_valid), 64'(0));
        check("mid_rst_flush", 64'(flush), 64'(0));
        check("mid_rst_busy", 64'(busy), 64'(0));
        check_cnts("mid_rst");
        drive_ex(32'h74, 32'h740, 1'b1);
        bif.redirect_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        bif.ex_valid = 1'b0;
        @(negedge clk);
        check("post_rst_rv", 64'(bif.redirect_valid), 64'(1));
        check("post_rst_pc", 64'(bif.redirect_pc), 64'(32'h740));
        wait_idle();
        @(negedge clk);
        check_cnts("post_rst");

        check("redir_queue_empty", 64'(exp_redir.size()), 64'(0));
        check("trap_queue_empty", 64'(exp_trap.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
